// File: rtl/mem_array_clr.sv
// rtl/mem_array_clr.sv - single-port data memory with a word-per-clock clear sequencer and debug read port
// Optional build macro MEM_RDREG_EN registers dout (1-cycle read latency, read-before-write).
module mem_array_clr #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic          clr,
  output logic [DW-1:0] dout,
  output logic          ready,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_dout
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [DW-1:0] mem [DEPTH];

  // Sequencer: ready is registered and tracks state (1 only in IDLE).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      ptr   <= '0;
      ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr) begin
            ptr <= '0;
          end else begin
            ptr <= ptr + 1'b1;
            if (ptr == {AW{1'b1}}) begin
              state <= IDLE;
              ready <= 1'b1;
            end
          end
        end
        default: begin
          if (clr) begin
            state <= CLEAR;
            ptr   <= '0;
            ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Array storage is deliberately not reset; the sequencer zeroes it after release.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (we && !clr) begin
      mem[addr] <= din;
    end
  end

  assign dbg_dout = mem[dbg_addr];

`ifdef MEM_RDREG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
    end else begin
      dout <= ready ? mem[addr] : '0;
    end
  end
`else
  assign dout = ready ? mem[addr] : '0;
`endif

endmodule

// File: tb/tb_mem_array_clr.sv
// tb/tb_mem_array_clr.sv - randomized self-checking bench for mem_array_clr against a word-array reference model
module tb_mem_array_clr;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] din = '0;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic          clr = 1'b0;
  logic [DW-1:0] dout;
  logic          ready;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_dout;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents, usable flag, and edges left before the clear finishes.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_ready;
  int            m_left;
  logic [DW-1:0] m_dout_reg;

  mem_array_clr #(.DW(DW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .addr     (addr),
    .we       (we),
    .clr      (clr),
    .dout     (dout),
    .ready    (ready),
    .dbg_addr (dbg_addr),
    .dbg_dout (dbg_dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready    = 1'b0;
    m_left     = DEPTH;
    m_dout_reg = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  // One rising edge of the reference behaviour, using the inputs currently applied.
  task automatic model_edge();
    logic [DW-1:0] rd;
    rd = m_ready ? m_mem[addr] : '0;
    if (!m_ready) begin
      if (clr) begin
        m_left = DEPTH;
      end else begin
        m_left--;
        if (m_left == 0) m_ready = 1'b1;
      end
    end else if (clr) begin
      m_ready = 1'b0;
      m_left  = DEPTH;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (we) begin
      m_mem[addr] = din;
    end
    m_dout_reg = rd;
  endtask

  task automatic check_outputs();
    #1;
    check("ready", {31'd0, ready}, {31'd0, m_ready});
`ifdef MEM_RDREG_EN
    check("dout", {24'd0, dout}, {24'd0, m_dout_reg});
`else
    check("dout", {24'd0, dout}, {24'd0, (m_ready ? m_mem[addr] : 8'h00)});
`endif
    if (m_ready) check("dbg_dout", {24'd0, dbg_dout}, {24'd0, m_mem[dbg_addr]});
  endtask

  // Called at a falling edge: apply inputs, check, advance model, step one clock.
  task automatic cycle(input logic c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    clr      = c;
    we       = w;
    addr     = a;
    din      = d;
    dbg_addr = AW'($urandom);
    check_outputs();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'($urandom), AW'($urandom), DW'($urandom));
  endtask

  initial begin
    model_reset();
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst = 1'b1;

    // Power-up clear: ready must rise exactly after the 256th edge.
    idle_cycles(DEPTH);
    check_outputs();
    check("ready_after_256", {31'd0, ready}, 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      dbg_addr = AW'(i);
      #1;
      check("dbg_sweep", {24'd0, dbg_dout}, 32'd0);
    end

    // Directed writes and reads.
    cycle(1'b0, 1'b1, 8'h10, 8'hA5);
    cycle(1'b0, 1'b1, 8'hFF, 8'h3C);
    cycle(1'b0, 1'b0, 8'h10, 8'h00);
    cycle(1'b0, 1'b0, 8'hFF, 8'h00);
    cycle(1'b0, 1'b0, 8'h11, 8'h00);
    cycle(1'b0, 1'b1, 8'h03, 8'h5A);
    cycle(1'b0, 1'b0, 8'h03, 8'h00);
    cycle(1'b0, 1'b0, 8'h03, 8'h00);
    idle_cycles(150);

    // Clear pulse with a write attempted mid-clear.
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    cycle(1'b0, 1'b1, 8'h20, 8'h77);
    idle_cycles(DEPTH);
    cycle(1'b0, 1'b0, 8'h20, 8'h00);
    check("mem20_cleared", {24'd0, m_mem[8'h20]}, 32'd0);
    idle_cycles(40);

    // Clear restarted at clear cycle 100.
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    idle_cycles(99);
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    idle_cycles(DEPTH + 4);

    // clr and we together: clr wins.
    cycle(1'b1, 1'b1, 8'h05, 8'hEE);
    idle_cycles(DEPTH);
    cycle(1'b0, 1'b0, 8'h05, 8'h00);
    dbg_addr = 8'h05;
    #1;
    check("mem05_dropped", {24'd0, dbg_dout}, 32'd0);
    @(negedge clk);
    idle_cycles(60);

    // Asynchronous reset mid-clear at ptr=50.
    cycle(1'b1, 1'b0, 8'h00, 8'h00);
    idle_cycles(50);
    #2;
    rst = 1'b0;
    #1;
    check("ready_async_rst", {31'd0, ready}, 32'd0);
    check("dout_async_rst", {24'd0, dout}, 32'd0);
    model_reset();
    repeat (2) begin
      @(negedge clk);
      check_outputs();
    end
    @(negedge clk);
    rst = 1'b1;
    idle_cycles(DEPTH);
    check_outputs();
    check("ready_after_rst", {31'd0, ready}, 32'd1);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 1500; i++)
      cycle(($urandom_range(0, 99) == 0), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
